// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the camera capture path
package cam_pkg;

   typedef enum logic {
      FMT_RGB565 = 1'b0,
      FMT_RGB444 = 1'b1
   } pix_fmt_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LINE_WAIT = 2'd1,
      BYTE_HI   = 2'd2,
      BYTE_LO   = 2'd3
   } cap_state_e;

   localparam logic [7:0] RGB332_RED   = 8'hE0;
   localparam logic [7:0] RGB332_GREEN = 8'h1C;
   localparam logic [7:0] RGB332_BLUE  = 8'h03;

endpackage

// File: rtl/cam_pix_conv.sv
// rtl/cam_pix_conv.sv - combinational two-byte camera pixel to RGB332 converter
module cam_pix_conv
   import cam_pkg::*;
(
   input  logic [7:0] hi,
   input  logic [7:0] lo,
   input  logic       mode,
   output logic [7:0] rgb
);

   // The two lowest bits of the low byte never reach RGB332 in either format.
   logic unused_lo;
   assign unused_lo = &{1'b0, lo[1:0]};

   always_comb begin
      rgb = {hi[7:5], hi[2:0], lo[4:3]};
      if (mode == FMT_RGB444) begin
         rgb = {hi[3:1], lo[7:5], lo[3:2]};
      end
   end

endmodule

// File: rtl/cam_capture_scaler.sv
// rtl/cam_capture_scaler.sv - OV7670 capture, RGB332 conversion and power-of-two decimation; CAM_CAPTURE_STATS_EN adds frame_cnt/line_err
module cam_capture_scaler
   import cam_pkg::*;
#(
   parameter int SRC_X = 640,
   parameter int SRC_Y = 480,
   parameter int DEC   = 4,
   parameter int AW    = 15,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    data,
   input  logic          mode,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          wr_en,
   output logic          frame_done,
   output logic          busy
`ifdef CAM_CAPTURE_STATS_EN
   ,
   output logic [15:0]   frame_cnt,
   output logic          line_err
`endif
);

   localparam int OUT_X = SRC_X / DEC;
   localparam int OUT_Y = SRC_Y / DEC;
   localparam int LAST  = OUT_X * OUT_Y - 1;
   localparam int CW    = 16;

   localparam logic [CW-1:0] DEC_MASK = CW'(DEC - 1);
   localparam logic [CW-1:0] SRC_X_L  = CW'(SRC_X);
   localparam logic [CW-1:0] SRC_Y_L  = CW'(SRC_Y);
   localparam logic [AW-1:0] LAST_A   = AW'(LAST);

   cap_state_e    state;
   logic          vsync_q;
   logic          href_q;
   logic          mode_q;
   logic [7:0]    hi_q;
   logic [CW-1:0] col;
   logic [CW-1:0] row;
   logic [AW-1:0] addr_cnt;
   logic          last_wr;
   logic [7:0]    pix_rgb;
   logic          keep;

   wire vsync_rise = vsync & ~vsync_q;
   wire vsync_fall = ~vsync & vsync_q;
   wire href_fall  = ~href & href_q;

   cam_pix_conv u_pix_conv (
      .hi   (hi_q),
      .lo   (data),
      .mode (mode_q),
      .rgb  (pix_rgb)
   );

   // Mask test works for DEC=1 too, where the low-bit field would be empty.
   assign keep = ((col & DEC_MASK) == '0) && ((row & DEC_MASK) == '0) &&
                 (col < SRC_X_L) && (row < SRC_Y_L) && !last_wr;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         mode_q     <= 1'b0;
         hi_q       <= '0;
         col        <= '0;
         row        <= '0;
         addr_cnt   <= '0;
         last_wr    <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
`ifdef CAM_CAPTURE_STATS_EN
         frame_cnt  <= '0;
         line_err   <= 1'b0;
`endif
      end else begin
         vsync_q    <= vsync;
         href_q     <= href;
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         last_wr    <= 1'b0;

         if (state != IDLE && vsync_rise) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
`ifdef CAM_CAPTURE_STATS_EN
            line_err <= 1'b1;
`endif
         end else if (last_wr) begin
            frame_done <= 1'b1;
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            addr_cnt   <= '0;
`ifdef CAM_CAPTURE_STATS_EN
            frame_cnt  <= frame_cnt + 16'd1;
`endif
         end else begin
            // Line end only counts while a line is actually being assembled.
            if (href_fall && (state == BYTE_HI || state == BYTE_LO)) begin
               col <= '0;
               if (row != '1) begin
                  row <= row + 1'b1;
               end
            end

            case (state)
               IDLE: begin
                  if (vsync_fall) begin
                     mode_q <= mode;
                     state  <= LINE_WAIT;
                  end
               end
               LINE_WAIT: begin
                  if (href) begin
                     hi_q  <= data;
                     state <= BYTE_HI;
                  end
               end
               BYTE_HI: begin
                  if (href) begin
                     state <= BYTE_LO;
                     if (col != '1) begin
                        col <= col + 1'b1;
                     end
                     if (keep) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_cnt;
                        wr_data <= pix_rgb;
                        if (addr_cnt == LAST_A) begin
                           last_wr <= 1'b1;
                        end else begin
                           addr_cnt <= addr_cnt + 1'b1;
                        end
                     end
                  end else begin
                     state <= LINE_WAIT;
`ifdef CAM_CAPTURE_STATS_EN
                     line_err <= 1'b1;
`endif
                  end
               end
               BYTE_LO: begin
                  if (href) begin
                     hi_q  <= data;
                     state <= BYTE_HI;
                  end else begin
                     state <= LINE_WAIT;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
